// File: rtl/rv32im_br_unit.sv
// ----------------------------------------------------------------------------
// rv32im_br_unit
//
// Branch/jump resolution for the RV32IM execute stage. The unit combines the
// ALU comparison flags with the branch funct3 code to decide whether the
// current instruction redirects fetch. It then registers the computed target,
// the taken flag and the next PC for the fetch unit.
//
// Timing: there is no handshake. Every rising clk_i edge samples the inputs
// and evaluates a new branch, so the outputs always reflect the inputs from
// the previous edge. rst_i is synchronous, active high, and overrides any
// input.
//
// Ports:
//   clk_i             clock; all state updates on the rising edge
//   rst_i             synchronous active-high reset
//   alu_zero_i        rs1 - rs2 == 0
//   alu_borrow_i      borrow out of rs1 - rs2 (rs1 < rs2 unsigned)
//   br_en_i           current instruction is a branch or jump
//   br_conditional_i  1 = B-type branch, 0 = JAL/JALR
//   exu_calc_addr     rs1 - rs2 for branches, jump target for JAL/JALR
//   br_opcode_i       funct3 branch code
//   curr_pc_i         PC of the current instruction
//   imm_i             sign-extended immediate
//   br_pc_o           registered computed target address
//   nxt_pc_o          registered next PC (target if taken, else curr_pc + 4)
//   br_taken_o        registered taken flag
// ----------------------------------------------------------------------------
module rv32im_br_unit #(
    parameter int unsigned              ADDR_WIDTH = 32,
    parameter int unsigned              DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0]    RESET_PC   = '0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  alu_zero_i,
    input  logic                  alu_borrow_i,
    input  logic                  br_en_i,
    input  logic                  br_conditional_i,
    input  logic [ADDR_WIDTH-1:0] exu_calc_addr,
    input  logic [2:0]            br_opcode_i,
    input  logic [ADDR_WIDTH-1:0] curr_pc_i,
    input  logic [DATA_WIDTH-1:0] imm_i,
    output logic [ADDR_WIDTH-1:0] br_pc_o,
    output logic [ADDR_WIDTH-1:0] nxt_pc_o,
    output logic                  br_taken_o
);

    // funct3 branch encodings; 010 and 011 are reserved and never taken.
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    logic                  lt_s;
    logic                  cond_ok;
    logic                  taken;
    logic [ADDR_WIDTH-1:0] imm_addr;
    logic [ADDR_WIDTH-1:0] target;
    logic [ADDR_WIDTH-1:0] fall_through;

    logic [ADDR_WIDTH-1:0] br_pc_q,    br_pc_d;
    logic [ADDR_WIDTH-1:0] nxt_pc_q,   nxt_pc_d;
    logic                  br_taken_q, br_taken_d;

    // Signed less-than is the sign of the raw difference; subtraction
    // overflow is deliberately not corrected.
    assign lt_s     = exu_calc_addr[ADDR_WIDTH-1];
    assign imm_addr = ADDR_WIDTH'(imm_i);

    always_comb begin
        cond_ok = 1'b0;
        case (br_opcode_i)
            F3_BEQ:  cond_ok = alu_zero_i;
            F3_BNE:  cond_ok = !alu_zero_i;
            F3_BLT:  cond_ok = lt_s && !alu_zero_i;
            F3_BGE:  cond_ok = !lt_s || alu_zero_i;
            F3_BLTU: cond_ok = alu_borrow_i && !alu_zero_i;
            F3_BGEU: cond_ok = !alu_borrow_i || alu_zero_i;
            default: cond_ok = 1'b0;
        endcase
    end

    // The mux form keeps an unknown funct3 from leaking into the result of
    // an unconditional jump.
    always_comb begin
        taken = 1'b0;
        if (br_en_i) begin
            taken = br_conditional_i ? cond_ok : 1'b1;
        end
    end

    // Targets are not alignment-checked; JAL/JALR only clear bit 0.
    always_comb begin
        target = {exu_calc_addr[ADDR_WIDTH-1:1], 1'b0};
        if (br_conditional_i) begin
            target = curr_pc_i + imm_addr;
        end
    end

    assign fall_through = curr_pc_i + ADDR_WIDTH'(4);

    always_comb begin
        br_pc_d    = target;
        br_taken_d = taken;
        nxt_pc_d   = taken ? target : fall_through;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            br_pc_q    <= '0;
            nxt_pc_q   <= RESET_PC;
            br_taken_q <= 1'b0;
        end else begin
            br_pc_q    <= br_pc_d;
            nxt_pc_q   <= nxt_pc_d;
            br_taken_q <= br_taken_d;
        end
    end

    assign br_pc_o    = br_pc_q;
    assign nxt_pc_o   = nxt_pc_q;
    assign br_taken_o = br_taken_q;

endmodule

// File: tb/tb_rv32im_br_unit.sv
module tb_rv32im_br_unit;

    localparam logic [31:0] TB_RESET_PC = 32'h8000_0100;

    // ---------------- clock / reset ----------------
    logic clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    logic        rst_i;
    logic        alu_zero_i;
    logic        alu_borrow_i;
    logic        br_en_i;
    logic        br_conditional_i;
    logic [31:0] exu_calc_addr;
    logic [2:0]  br_opcode_i;
    logic [31:0] curr_pc_i;
    logic [31:0] imm_i;
    logic [31:0] br_pc_o;
    logic [31:0] nxt_pc_o;
    logic        br_taken_o;

    int n_checks = 0;
    int n_fail   = 0;

    rv32im_br_unit #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .RESET_PC   (TB_RESET_PC)
    ) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .alu_zero_i       (alu_zero_i),
        .alu_borrow_i     (alu_borrow_i),
        .br_en_i          (br_en_i),
        .br_conditional_i (br_conditional_i),
        .exu_calc_addr    (exu_calc_addr),
        .br_opcode_i      (br_opcode_i),
        .curr_pc_i        (curr_pc_i),
        .imm_i            (imm_i),
        .br_pc_o          (br_pc_o),
        .nxt_pc_o         (nxt_pc_o),
        .br_taken_o       (br_taken_o)
    );

    // ---------------- driver ----------------
    // Apply one set of inputs, let one rising edge capture them, and return
    // 1ns later so outputs are sampled away from the edge.
    task automatic drive(input logic en, input logic cond, input logic [2:0] op,
                         input logic zero, input logic borrow,
                         input logic [31:0] calc, input logic [31:0] pc,
                         input logic [31:0] imm);
        br_en_i          = en;
        br_conditional_i = cond;
        br_opcode_i      = op;
        alu_zero_i       = zero;
        alu_borrow_i     = borrow;
        exu_calc_addr    = calc;
        curr_pc_i        = pc;
        imm_i            = imm;
        @(posedge clk_i);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_i = 1'b1;
        drive(1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 32'hffeeddcd, 32'h001ffff3, 32'h0);
        drive(1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 32'hffeeddcd, 32'h001ffff3, 32'h0);
        n_checks++;
        if (nxt_pc_o !== TB_RESET_PC) begin
            n_fail++; $display("FAIL reset_nxt_pc: got %h expected %h", nxt_pc_o, TB_RESET_PC);
        end
        n_checks++;
        if (br_pc_o !== 32'h0) begin
            n_fail++; $display("FAIL reset_br_pc: got %h expected %h", br_pc_o, 32'h0);
        end
        n_checks++;
        if (br_taken_o !== 1'b0) begin
            n_fail++; $display("FAIL reset_taken: got %b expected 0", br_taken_o);
        end
        rst_i = 1'b0;
        drive(1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 32'hffeeddcd, 32'h001ffff3, 32'h0);
        n_checks++;
        if (br_taken_o !== 1'b1 || nxt_pc_o !== 32'hffeeddcc) begin
            n_fail++; $display("FAIL post_reset_eval: got taken=%b nxt=%h expected taken=1 nxt=ffeeddcc",
                               br_taken_o, nxt_pc_o);
        end
    endtask

    task automatic test_jump();
        drive(1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 32'hffeeddcd, 32'h001ffff3, 32'h0);
        n_checks++;
        if (br_taken_o !== 1'b1 || br_pc_o !== 32'hffeeddcc || nxt_pc_o !== 32'hffeeddcc) begin
            n_fail++; $display("FAIL jump_odd: got taken=%b br_pc=%h nxt=%h expected 1 ffeeddcc ffeeddcc",
                               br_taken_o, br_pc_o, nxt_pc_o);
        end
        // Reserved funct3 and "not-equal" flags are irrelevant to a jump.
        drive(1'b1, 1'b0, 3'b010, 1'b0, 1'b1, 32'h12345678, 32'h00000100, 32'h00000040);
        n_checks++;
        if (br_taken_o !== 1'b1 || br_pc_o !== 32'h12345678 || nxt_pc_o !== 32'h12345678) begin
            n_fail++; $display("FAIL jump_even: got taken=%b br_pc=%h nxt=%h expected 1 12345678 12345678",
                               br_taken_o, br_pc_o, nxt_pc_o);
        end
    endtask

    task automatic test_x_opcode();
        drive(1'b1, 1'b0, 3'bxxx, 1'b0, 1'b0, 32'h0000abcd, 32'h00000010, 32'h0);
        n_checks++;
        if (br_taken_o !== 1'b1 || nxt_pc_o !== 32'h0000abcc || br_pc_o !== 32'h0000abcc) begin
            n_fail++; $display("FAIL jump_x_opcode: got taken=%b br_pc=%h nxt=%h expected 1 0000abcc 0000abcc",
                               br_taken_o, br_pc_o, nxt_pc_o);
        end
    endtask

    task automatic test_beq();
        drive(1'b1, 1'b1, 3'b000, 1'b0, 1'b0, 32'h00000005, 32'h001ffff3, 32'h00abcdef);
        n_checks++;
        if (br_taken_o !== 1'b0 || nxt_pc_o !== 32'h001ffff7 || br_pc_o !== 32'h00cbcde2) begin
            n_fail++; $display("FAIL beq_ne: got taken=%b br_pc=%h nxt=%h expected 0 00cbcde2 001ffff7",
                               br_taken_o, br_pc_o, nxt_pc_o);
        end
        drive(1'b1, 1'b1, 3'b000, 1'b1, 1'b0, 32'h00000000, 32'h001ffff3, 32'h00abcdef);
        n_checks++;
        if (br_taken_o !== 1'b1 || nxt_pc_o !== 32'h00cbcde2 || br_pc_o !== 32'h00cbcde2) begin
            n_fail++; $display("FAIL beq_eq: got taken=%b br_pc=%h nxt=%h expected 1 00cbcde2 00cbcde2",
                               br_taken_o, br_pc_o, nxt_pc_o);
        end
    endtask

    task automatic test_bne();
        drive(1'b1, 1'b1, 3'b001, 1'b1, 1'b0, 32'h00000000, 32'h00000003, 32'h00abcdee);
        n_checks++;
        if (br_taken_o !== 1'b0 || nxt_pc_o !== 32'h00000007) begin
            n_fail++; $display("FAIL bne_eq: got taken=%b nxt=%h expected 0 00000007", br_taken_o, nxt_pc_o);
        end
        drive(1'b1, 1'b1, 3'b001, 1'b0, 1'b0, 32'h00000005, 32'h00000003, 32'h00abcdee);
        n_checks++;
        if (br_taken_o !== 1'b1 || nxt_pc_o !== 32'h00abcdf1) begin
            n_fail++; $display("FAIL bne_ne: got taken=%b nxt=%h expected 1 00abcdf1", br_taken_o, nxt_pc_o);
        end
    endtask

    task automatic test_blt_bge();
        logic [31:0] res    [3] = '{32'h00000009, 32'h00000000, 32'hfffffff7};
        logic        zero   [3] = '{1'b0, 1'b1, 1'b0};
        logic        exp_lt [3] = '{1'b0, 1'b0, 1'b1};
        logic        exp_ge [3] = '{1'b1, 1'b1, 1'b0};
        logic [31:0] exp_nxt;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 3'b100, zero[i], 1'b0, res[i], 32'h001ffff3, 32'h00abcdef);
            exp_nxt = exp_lt[i] ? 32'h00cbcde2 : 32'h001ffff7;
            n_checks++;
            if (br_taken_o !== exp_lt[i] || nxt_pc_o !== exp_nxt) begin
                n_fail++; $display("FAIL blt[%0d]: got taken=%b nxt=%h expected %b %h",
                                   i, br_taken_o, nxt_pc_o, exp_lt[i], exp_nxt);
            end
            drive(1'b1, 1'b1, 3'b101, zero[i], 1'b0, res[i], 32'h001ffff3, 32'h00abcdef);
            exp_nxt = exp_ge[i] ? 32'h00cbcde2 : 32'h001ffff7;
            n_checks++;
            if (br_taken_o !== exp_ge[i] || nxt_pc_o !== exp_nxt) begin
                n_fail++; $display("FAIL bge[%0d]: got taken=%b nxt=%h expected %b %h",
                                   i, br_taken_o, nxt_pc_o, exp_ge[i], exp_nxt);
            end
        end
    endtask

    task automatic test_unsigned();
        logic zero    [3] = '{1'b1, 1'b0, 1'b0};
        logic borrow  [3] = '{1'b1, 1'b1, 1'b0};
        logic exp_ltu [3] = '{1'b0, 1'b1, 1'b0};
        logic exp_geu [3] = '{1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 3'b110, zero[i], borrow[i], 32'h00000000, 32'h00001000, 32'h00000080);
            n_checks++;
            if (br_taken_o !== exp_ltu[i] || nxt_pc_o !== (exp_ltu[i] ? 32'h00001080 : 32'h00001004)) begin
                n_fail++; $display("FAIL bltu[%0d]: got taken=%b nxt=%h expected taken=%b",
                                   i, br_taken_o, nxt_pc_o, exp_ltu[i]);
            end
            drive(1'b1, 1'b1, 3'b111, zero[i], borrow[i], 32'h00000000, 32'h00001000, 32'h00000080);
            n_checks++;
            if (br_taken_o !== exp_geu[i] || nxt_pc_o !== (exp_geu[i] ? 32'h00001080 : 32'h00001004)) begin
                n_fail++; $display("FAIL bgeu[%0d]: got taken=%b nxt=%h expected taken=%b",
                                   i, br_taken_o, nxt_pc_o, exp_geu[i]);
            end
        end
    endtask

    task automatic test_reserved();
        drive(1'b1, 1'b1, 3'b010, 1'b1, 1'b1, 32'h00000000, 32'h00000200, 32'h00000010);
        n_checks++;
        if (br_taken_o !== 1'b0 || nxt_pc_o !== 32'h00000204 || br_pc_o !== 32'h00000210) begin
            n_fail++; $display("FAIL reserved_010: got taken=%b br_pc=%h nxt=%h expected 0 00000210 00000204",
                               br_taken_o, br_pc_o, nxt_pc_o);
        end
        drive(1'b1, 1'b1, 3'b011, 1'b0, 1'b0, 32'h80000000, 32'h00000200, 32'h00000010);
        n_checks++;
        if (br_taken_o !== 1'b0 || nxt_pc_o !== 32'h00000204) begin
            n_fail++; $display("FAIL reserved_011: got taken=%b nxt=%h expected 0 00000204", br_taken_o, nxt_pc_o);
        end
    endtask

    task automatic test_disable();
        drive(1'b0, 1'b0, 3'b000, 1'b1, 1'b1, 32'hffeeddcd, 32'h001ffff3, 32'h00abcdef);
        n_checks++;
        if (br_taken_o !== 1'b0 || nxt_pc_o !== 32'h001ffff7 || br_pc_o !== 32'hffeeddcc) begin
            n_fail++; $display("FAIL disable_jump: got taken=%b br_pc=%h nxt=%h expected 0 ffeeddcc 001ffff7",
                               br_taken_o, br_pc_o, nxt_pc_o);
        end
        drive(1'b0, 1'b1, 3'b000, 1'b1, 1'b0, 32'h00000000, 32'h001ffff3, 32'h00abcdef);
        n_checks++;
        if (br_taken_o !== 1'b0 || nxt_pc_o !== 32'h001ffff7) begin
            n_fail++; $display("FAIL disable_beq: got taken=%b nxt=%h expected 0 001ffff7", br_taken_o, nxt_pc_o);
        end
        drive(1'b1, 1'b1, 3'b001, 1'b1, 1'b0, 32'h00000000, 32'hfffffffc, 32'h00000010);
        n_checks++;
        if (br_taken_o !== 1'b0 || nxt_pc_o !== 32'h00000000) begin
            n_fail++; $display("FAIL fallthrough_wrap: got taken=%b nxt=%h expected 0 00000000", br_taken_o, nxt_pc_o);
        end
    endtask

    task automatic test_target_wrap();
        drive(1'b1, 1'b1, 3'b000, 1'b1, 1'b0, 32'h00000000, 32'hfffffff0, 32'h00000020);
        n_checks++;
        if (br_taken_o !== 1'b1 || nxt_pc_o !== 32'h00000010) begin
            n_fail++; $display("FAIL target_wrap: got taken=%b nxt=%h expected 1 00000010", br_taken_o, nxt_pc_o);
        end
        drive(1'b1, 1'b1, 3'b000, 1'b1, 1'b0, 32'h00000000, 32'h00001000, 32'hfffffff0);
        n_checks++;
        if (br_taken_o !== 1'b1 || nxt_pc_o !== 32'h00000ff0) begin
            n_fail++; $display("FAIL target_neg_imm: got taken=%b nxt=%h expected 1 00000ff0", br_taken_o, nxt_pc_o);
        end
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 32'h00004001, 32'h00000040, 32'h0);
        n_checks++;
        if (nxt_pc_o !== 32'h00004000) begin
            n_fail++; $display("FAIL b2b_0: got nxt=%h expected 00004000", nxt_pc_o);
        end
        drive(1'b1, 1'b1, 3'b001, 1'b1, 1'b0, 32'h00000000, 32'h00004000, 32'h00000100);
        n_checks++;
        if (nxt_pc_o !== 32'h00004004 || br_pc_o !== 32'h00004100) begin
            n_fail++; $display("FAIL b2b_1: got nxt=%h br_pc=%h expected 00004004 00004100", nxt_pc_o, br_pc_o);
        end
        // Mid-stream reset wins over a taken jump.
        rst_i = 1'b1;
        drive(1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 32'h00008000, 32'h00004004, 32'h0);
        n_checks++;
        if (br_taken_o !== 1'b0 || nxt_pc_o !== TB_RESET_PC || br_pc_o !== 32'h0) begin
            n_fail++; $display("FAIL midstream_reset: got taken=%b br_pc=%h nxt=%h expected 0 00000000 %h",
                               br_taken_o, br_pc_o, nxt_pc_o, TB_RESET_PC);
        end
        rst_i = 1'b0;
        drive(1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 32'h00008000, 32'h00004004, 32'h0);
        n_checks++;
        if (br_taken_o !== 1'b1 || nxt_pc_o !== 32'h00008000) begin
            n_fail++; $display("FAIL after_midstream_reset: got taken=%b nxt=%h expected 1 00008000",
                               br_taken_o, nxt_pc_o);
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        rst_i            = 1'b1;
        alu_zero_i       = 1'b0;
        alu_borrow_i     = 1'b0;
        br_en_i          = 1'b0;
        br_conditional_i = 1'b0;
        exu_calc_addr    = '0;
        br_opcode_i      = '0;
        curr_pc_i        = '0;
        imm_i            = '0;
        @(negedge clk_i);

        test_reset();
        test_jump();
        test_x_opcode();
        test_beq();
        test_bne();
        test_blt_bge();
        test_unsigned();
        test_reserved();
        test_disable();
        test_target_wrap();
        test_back_to_back();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rv32im_br_unit.md
Name: rv32im_br_unit

Overview:
RV32IM branch/jump resolution unit in the execute stage. It takes the ALU comparison flags and the computed jump address for the current instruction and decides whether the branch is taken. It produces the branch target and the next PC for the fetch unit. Outputs are registered: one clock, synchronous active-high reset.

Parameters:
ADDR_WIDTH, 32, width of PC and address values
DATA_WIDTH, 32, width of the immediate and ALU data
RESET_PC, 32'h0000_0000, value of nxt_pc_o while in reset

Ports:
clk_i  in  1  clock, all state updates on rising edge
rst_i  in  1  synchronous active-high reset
alu_zero_i  in  1  ALU result of rs1-rs2 equals zero (rs1==rs2)
alu_borrow_i  in  1  borrow out of rs1-rs2 (rs1<rs2 unsigned)
br_en_i  in  1  current instruction is a branch or jump
br_conditional_i  in  1  1 = conditional branch (B-type), 0 = unconditional jump (JAL/JALR)
exu_calc_addr  in  ADDR_WIDTH  ALU output: rs1-rs2 for branches, jump target address for JAL/JALR
br_opcode_i  in  3  funct3 branch code
curr_pc_i  in  ADDR_WIDTH  PC of current instruction
imm_i  in  DATA_WIDTH  sign-extended immediate
br_pc_o  out  ADDR_WIDTH  registered computed target address
nxt_pc_o  out  ADDR_WIDTH  registered next PC (target if taken, else curr_pc+4)
br_taken_o  out  1  registered taken flag

Behaviour:
- Opcode encoding (funct3): BEQ 000, BNE 001, BLT 100, BGE 101, BLTU 110, BGEU 111. Codes 010 and 011 are reserved and always not-taken.
- Condition evaluation (combinational), using lt_s = exu_calc_addr[ADDR_WIDTH-1]:
  - BEQ: alu_zero_i
  - BNE: !alu_zero_i
  - BLT: lt_s && !alu_zero_i
  - BGE: !lt_s || alu_zero_i
  - BLTU: alu_borrow_i && !alu_zero_i
  - BGEU: !alu_borrow_i || alu_zero_i
- Signed compare uses only the difference sign bit; overflow of the subtraction is not corrected.
- Target address:
  - Conditional: curr_pc_i + imm_i, modulo 2^ADDR_WIDTH.
  - Unconditional: exu_calc_addr with bit 0 cleared.
- No alignment check on any target; odd PCs pass through unchanged, and a misaligned target is not trapped here.
- taken = br_en_i && (!br_conditional_i || condition). br_en_i=0 forces not-taken regardless of the other inputs. br_opcode_i is ignored when br_conditional_i=0.
- Fall-through = curr_pc_i + 4, wrapping at 2^ADDR_WIDTH.
- Register update on each rising clk_i edge when not in reset:
  - br_pc_o <= target (always, taken or not)
  - br_taken_o <= taken
  - nxt_pc_o <= taken ? target : fall-through
- Latency: outputs reflect the inputs sampled at the previous rising edge. No handshake; a new evaluation happens every cycle.
- Reset: while rst_i=1 at an edge, br_pc_o=0, br_taken_o=0, nxt_pc_o=RESET_PC. Reset wins over any input, including mid-stream. The first post-reset edge computes from the inputs normally.
- X/undefined br_opcode_i with br_conditional_i=0 must not affect the outputs.

Test Plan:
- Reset: hold rst_i=1 for 2 edges -> nxt_pc_o=RESET_PC, br_pc_o=0, br_taken_o=0. Release -> next edge evaluates the inputs.
- Jump: br_en=1, cond=0, exu_calc_addr=ffeeddcd, pc=001ffff3 -> taken=1, br_pc_o=nxt_pc_o=ffeeddcc.
- BEQ, pc=001ffff3, imm=00abcdef:
  - zero=0 -> taken=0, nxt_pc_o=001ffff7, br_pc_o=00cbcde2
  - zero=1 -> taken=1, nxt_pc_o=00cbcde2
- BNE, pc=00000003, imm=00abcdee:
  - zero=1 -> nxt_pc_o=00000007
  - zero=0, result=5 -> nxt_pc_o=00abcdf1
- BLT/BGE with result 9, 0, fffffff7 (imm=00abcdef, pc=001ffff3):
  - BLT taken only for fffffff7
  - BGE taken for 0 and 9
  - taken -> 00cbcde2, not taken -> 001ffff7
- BLTU/BGEU and disable:
  - zero=1 -> BLTU not taken, BGEU taken
  - zero=0, borrow=1 -> BLTU taken, BGEU not taken
  - br_en=0 with any inputs -> taken=0, nxt_pc_o=pc+4
  - pc=fffffffc, not taken -> nxt_pc_o=00000000
